// File: rtl/test_pkg.sv
// Shared types for the riscv-tests regression sequencer: FSM states,
// tohost result kinds and the tohost "pass" value.
package test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    PASS,
    FAIL,
    TIMEOUT
  } result_t;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

endpackage

// File: rtl/tohost_decode.sv
// Combinational decode of a core store into a tohost result: only a
// full-word store to TOHOST_ADDR counts; even values are syscalls and ignored.
module tohost_decode
  import test_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] memIn,
  input  logic [3:0]  wrMask,
  output result_t     kind,
  output logic [30:0] failCode
);

  logic hit;

  assign hit = memWr && (memAddr == TOHOST_ADDR) && (wrMask == 4'b1111);

  always_comb begin
    kind     = NONE;
    failCode = memIn[31:1];
    if (hit) begin
      if (memIn == TOHOST_PASS) begin
        kind = PASS;
      end else if (memIn[0]) begin
        kind = FAIL;
      end
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Runs NUM_TESTS riscv-tests images back-to-back on the core: hold reset while
// memory reloads, run until tohost or timeout, record per-test results.
module test_sequencer
  import test_pkg::*;
#(
  parameter int          NUM_TESTS      = 38,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int          RESET_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 100000,
  localparam int         IDX_W          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int         CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 memWr,
  input  logic [31:0]          memAddr,
  input  logic [31:0]          memIn,
  input  logic [3:0]           wrMask,
  output logic                 cpuReset,
  output logic [IDX_W-1:0]     testIdx,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_TESTS-1:0] passMask,
  output logic [NUM_TESTS-1:0] failMask,
  output logic [NUM_TESTS-1:0] timeoutMask,
  output logic [30:0]          failCode,
  output logic [CNT_W-1:0]     lastCycles
);

  localparam int               HOLD_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TESTS - 1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  run_cnt;
  result_t           kind;
  logic [30:0]       dec_code;
  logic              timeout_hit;

  tohost_decode #(
    .TOHOST_ADDR(TOHOST_ADDR)
  ) u_decode (
    .memWr   (memWr),
    .memAddr (memAddr),
    .memIn   (memIn),
    .wrMask  (wrMask),
    .kind    (kind),
    .failCode(dec_code)
  );

  assign timeout_hit = (run_cnt == RUN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpuReset    <= 1'b1;
      testIdx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      passMask    <= '0;
      failMask    <= '0;
      timeoutMask <= '0;
      failCode    <= '0;
      lastCycles  <= '0;
      hold_cnt    <= '0;
      run_cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HOLD;
            cpuReset    <= 1'b1;
            testIdx     <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            passMask    <= '0;
            failMask    <= '0;
            timeoutMask <= '0;
            failCode    <= '0;
            hold_cnt    <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= RUN;
            cpuReset <= 1'b0;
            run_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          // A tohost write in the timeout cycle takes priority over the timeout.
          if (kind != NONE || timeout_hit) begin
            case (kind)
              PASS: passMask[testIdx] <= 1'b1;
              FAIL: begin
                failMask[testIdx] <= 1'b1;
                failCode          <= dec_code;
              end
              default: timeoutMask[testIdx] <= 1'b1;
            endcase
            lastCycles <= run_cnt + 1'b1;
            cpuReset   <= 1'b1;
            if (testIdx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= HOLD;
              testIdx  <= testIdx + 1'b1;
              hold_cnt <= '0;
            end
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: a stub core driven from a table of
// per-test programs, plus hand-written reset/abort and restart sequences.
module tb_test_sequencer;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] memIn;
  logic [3:0]  wrMask;
  logic        cpuReset;
  logic [1:0]  testIdx;
  logic        busy;
  logic        done;
  logic [2:0]  passMask;
  logic [2:0]  failMask;
  logic [2:0]  timeoutMask;
  logic [30:0] failCode;
  logic [5:0]  lastCycles;

  int checks;
  int failures;

  // Per-test fields are packed with test 2 in the top slice, test 0 in the bottom.
  typedef struct packed {
    logic [2:0]        wr_en;
    logic [2:0][7:0]   wr_at;
    logic [2:0][31:0]  wr_data;
    logic [2:0]        noise;
    logic [2:0]        exp_pass;
    logic [2:0]        exp_fail;
    logic [2:0]        exp_to;
    logic [30:0]       exp_code;
    logic [2:0][7:0]   exp_last;
  } vec_t;

  vec_t vecs [6];
  vec_t abort_vec;

  test_sequencer #(
    .NUM_TESTS     (3),
    .TOHOST_ADDR   (TOHOST),
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .memWr      (memWr),
    .memAddr    (memAddr),
    .memIn      (memIn),
    .wrMask     (wrMask),
    .cpuReset   (cpuReset),
    .testIdx    (testIdx),
    .busy       (busy),
    .done       (done),
    .passMask   (passMask),
    .failMask   (failMask),
    .timeoutMask(timeoutMask),
    .failCode   (failCode),
    .lastCycles (lastCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    memWr   = 1'b1;
    memAddr = addr;
    memIn   = data;
    wrMask  = mask;
  endtask

  // Stub core: drives the store bus for run cycle rc of test cur.
  task automatic drive_core(input vec_t v, input int cur, input int rc);
    if (rc == 1) start = 1'b1;
    if (v.noise[cur]) begin
      if (rc == 2) store(TOHOST, 32'd1, 4'b0001);
      if (rc == 4) store(TOHOST, 32'd2, 4'b1111);
      if (rc == 5) store(TOHOST + 32'd4, 32'd1, 4'b1111);
    end
    if (v.wr_en[cur] && rc == int'(v.wr_at[cur])) store(TOHOST, v.wr_data[cur], 4'b1111);
  endtask

  task automatic applyStimulus(input vec_t v, input int n, input int abort_test, output logic aborted);
    int  cur;
    int  rc;
    int  hold_len;
    logic prev_run;
    logic finished;
    string tag;
    tag = $sformatf("v%0d", n);
    cur = 0; rc = 0; hold_len = 0; prev_run = 1'b0; finished = 1'b0; aborted = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_start_busy"}, busy, 1);
    checkOutput({tag, "_start_done"}, done, 0);
    checkOutput({tag, "_start_masks"}, {passMask, failMask, timeoutMask}, 0);
    checkOutput({tag, "_start_code"}, failCode, 0);
    for (int cyc = 0; cyc < 1500 && !finished && !aborted; cyc++) begin
      memWr = 1'b0; memAddr = '0; memIn = '0; wrMask = '0; start = 1'b0;
      if (!cpuReset) begin
        if (!prev_run) checkOutput($sformatf("%s_hold_len_t%0d", tag, cur), hold_len, 4);
        prev_run = 1'b1;
        drive_core(v, cur, rc);
        if (cur == abort_test && rc == 5) aborted = 1'b1;
        rc++;
      end else begin
        if (prev_run) begin
          checkOutput($sformatf("%s_last_t%0d", tag, cur), lastCycles, v.exp_last[cur]);
          cur++;
          rc = 0; hold_len = 0; prev_run = 1'b0;
        end
        if (done) finished = 1'b1;
        else if (busy) begin
          hold_len++;
          checkOutput($sformatf("%s_idx_hold_t%0d", tag, cur), testIdx, cur);
        end
      end
      if (!finished && !aborted) @(negedge clk);
    end
    if (!finished && !aborted) checkOutput({tag, "_suite_budget"}, 0, 1);
    if (finished) begin
      checkOutput({tag, "_pass"}, passMask, v.exp_pass);
      checkOutput({tag, "_fail"}, failMask, v.exp_fail);
      checkOutput({tag, "_timeout"}, timeoutMask, v.exp_to);
      checkOutput({tag, "_code"}, failCode, v.exp_code);
      checkOutput({tag, "_busy_end"}, busy, 0);
      checkOutput({tag, "_cpureset_end"}, cpuReset, 1);
      checkOutput({tag, "_tests_done"}, cur, 3);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_cpureset"}, cpuReset, 1);
    checkOutput({tag, "_idx"}, testIdx, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_masks"}, {passMask, failMask, timeoutMask}, 0);
    checkOutput({tag, "_code"}, failCode, 0);
    checkOutput({tag, "_last"}, lastCycles, 0);
  endtask

  initial begin
    logic aborted;
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0;
    memWr = 1'b0; memAddr = '0; memIn = '0; wrMask = '0;

    vecs[0] = '{wr_en: 3'b111, wr_at: {8'd9, 8'd9, 8'd9}, wr_data: {32'd1, 32'd1, 32'd1},
                noise: 3'b000, exp_pass: 3'b111, exp_fail: 3'b000, exp_to: 3'b000,
                exp_code: 31'd0, exp_last: {8'd10, 8'd10, 8'd10}};
    vecs[1] = '{wr_en: 3'b111, wr_at: {8'd9, 8'd9, 8'd9}, wr_data: {32'd1, 32'h7, 32'd1},
                noise: 3'b000, exp_pass: 3'b101, exp_fail: 3'b010, exp_to: 3'b000,
                exp_code: 31'd3, exp_last: {8'd10, 8'd10, 8'd10}};
    vecs[2] = '{wr_en: 3'b110, wr_at: {8'd9, 8'd9, 8'd0}, wr_data: {32'd1, 32'd1, 32'd0},
                noise: 3'b000, exp_pass: 3'b110, exp_fail: 3'b000, exp_to: 3'b001,
                exp_code: 31'd0, exp_last: {8'd10, 8'd10, 8'd50}};
    vecs[3] = '{wr_en: 3'b111, wr_at: {8'd0, 8'd20, 8'd9}, wr_data: {32'd1, 32'd5, 32'd1},
                noise: 3'b001, exp_pass: 3'b101, exp_fail: 3'b010, exp_to: 3'b000,
                exp_code: 31'd2, exp_last: {8'd1, 8'd21, 8'd10}};
    vecs[4] = '{wr_en: 3'b011, wr_at: {8'd0, 8'd49, 8'd49}, wr_data: {32'd0, 32'd3, 32'd1},
                noise: 3'b000, exp_pass: 3'b001, exp_fail: 3'b010, exp_to: 3'b100,
                exp_code: 31'd1, exp_last: {8'd50, 8'd50, 8'd50}};
    vecs[5] = '{wr_en: 3'b111, wr_at: {8'd7, 8'd3, 8'd7}, wr_data: {32'hFFFF_FFFF, 32'd1, 32'd9},
                noise: 3'b000, exp_pass: 3'b010, exp_fail: 3'b101, exp_to: 3'b000,
                exp_code: 31'h7FFF_FFFF, exp_last: {8'd8, 8'd4, 8'd8}};
    abort_vec = '{wr_en: 3'b001, wr_at: {8'd0, 8'd0, 8'd3}, wr_data: {32'd0, 32'd0, 32'd7},
                  noise: 3'b000, exp_pass: 3'b000, exp_fail: 3'b001, exp_to: 3'b000,
                  exp_code: 31'd3, exp_last: {8'd0, 8'd0, 8'd4}};

    repeat (2) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_cpureset", cpuReset, 1);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i, -1, aborted);

    // Reset pulsed in the middle of test 1's run discards partial results.
    applyStimulus(abort_vec, 6, 1, aborted);
    checkOutput("abort_reached", aborted, 1);
    checkOutput("abort_partial_fail", failMask, 3'b001);
    checkOutput("abort_partial_code", failCode, 3);
    checkOutput("abort_running", cpuReset, 0);
    reset = 1'b1; memWr = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_idle_busy", busy, 0);

    applyStimulus(vecs[1], 7, -1, aborted);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Synthesizable regression sequencer that runs NUM_TESTS riscv-tests programs back-to-back on the `cpu` core. It holds the core in reset while the instruction/data memory loads the selected image, releases it, and watches the store bus for the `tohost` write that ends each test. Per-test pass, fail and timeout results are recorded in bitmaps. It sits beside `cpu` and the memory model in the top-level test harness, and replaces a hand-written bench loop over the hex-file list.

## Interface
- NUM_TESTS, 38, number of test images; memory bank index range is 0..NUM_TESTS-1.
- TOHOST_ADDR, 32'h0000_1000, byte address of the `tohost` word.
- RESET_CYCLES, 4, cycles `cpuReset` is held per test; must be ≥1.
- TIMEOUT_CYCLES, 100000, maximum run cycles per test; must be ≥2.
- Derived: IDX_W = max(1, $clog2(NUM_TESTS)); CNT_W = $clog2(TIMEOUT_CYCLES+1).
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to run the whole suite.
- memWr  in  1  core store strobe.
- memAddr  in  32  core store byte address.
- memIn  in  32  core store data.
- wrMask  in  4  core store byte enables.
- cpuReset  out  1  reset to `cpu`, registered.
- testIdx  out  IDX_W  image bank select for memory, registered.
- busy  out  1  suite in progress.
- done  out  1  suite finished; results valid.
- passMask  out  NUM_TESTS  bit i set when test i passed.
- failMask  out  NUM_TESTS  bit i set when test i reported failure.
- timeoutMask  out  NUM_TESTS  bit i set when test i timed out.
- failCode  out  31  tohost>>1 of the most recent failing test.
- lastCycles  out  CNT_W  run cycles of the most recently finished test.

## Operation
- States: IDLE, HOLD, RUN, DONE.
- Reset values: state IDLE, cpuReset 1, testIdx 0, busy 0, done 0, all masks 0, failCode 0, lastCycles 0, counters 0.
- IDLE: on start, clear all masks and failCode, set testIdx 0, and go to HOLD.
- HOLD: cpuReset is 1. The hold counter counts RESET_CYCLES cycles, then the state goes to RUN and the run counter is cleared.
- RUN: cpuReset is 0. The run counter increments every cycle.
- Tohost event: memWr=1, memAddr==TOHOST_ADDR and wrMask==4'b1111. Writes that match on address but have a partial mask are ignored.
  - Data 1 → pass.
  - Odd data ≠1 → fail; failCode ← data[31:1].
  - Even data (syscall) → ignored; the test keeps running.
- Timeout: run counter == TIMEOUT_CYCLES-1 with no terminating event in that cycle → timeoutMask[testIdx] set.
- On terminate (pass, fail or timeout):
  - set the result bit and set lastCycles ← run counter + 1;
  - if testIdx == NUM_TESTS-1, go to DONE;
  - otherwise testIdx increments and the state goes to HOLD.
- Exactly one of the three mask bits is set per completed test.
- DONE: cpuReset is 1, done is 1, results are held. A start in DONE restarts exactly as from IDLE.
- start outside IDLE and DONE is ignored.
- busy = (state is HOLD or RUN).

## Timing
- start sampled at edge k → HOLD from k+1, with cpuReset=1 and testIdx=0.
- RUN begins RESET_CYCLES cycles after HOLD entry. testIdx is stable for the whole HOLD phase, so the memory reloads in that window.
- A terminating write sampled at edge k → from k+1: result bit visible, cpuReset=1, and either the new testIdx or DONE.
- Simultaneous terminating write and timeout condition: the write wins (pass/fail, not timeout).
- reset asserted mid-run: every output returns to its reset value at the next edge. Partial results are discarded.
- Run counter cannot wrap: the timeout fires before it reaches 2^CNT_W-1.

## Structure
- Package `test_pkg`: state enum, TOHOST_PASS=32'd1 constant, and the result-kind enum {NONE, PASS, FAIL, TIMEOUT}.
- Sub-module `tohost_decode` (combinational): inputs memWr, memAddr, memIn, wrMask; outputs the result kind and failCode. Parametrised on TOHOST_ADDR.
- Top module holds the FSM, hold/run counters, and result registers.

## Test plan
- NUM_TESTS=3, RESET_CYCLES=4. Stub core writes 1 to tohost after 10 run cycles on every test → passMask=3'b111, done=1, lastCycles=10, each test holds cpuReset for 4 cycles.
- Test 1 writes 32'h0000_0007 → failMask=3'b010, failCode=3. Tests 0 and 2 pass.
- TIMEOUT_CYCLES=50, test 0 never writes → timeoutMask bit0 set after exactly 50 run cycles, lastCycles=50. Testing continues with test 1.
- Write of 1 to tohost with wrMask=4'b0001, then an even value 32'h2 → both ignored; a later full-word 1 passes.
- Tohost write on the timeout cycle → pass recorded, not timeout.
- reset pulsed during RUN of test 1 → next cycle IDLE, cpuReset=1, masks 0. A start from DONE clears the previous masks.
